// File: rtl/cdb_arbiter.sv
// Result-bus arbiter: per-producer FIFOs feeding NUM_CDB registered broadcast channels, rotating priority.
// Latency 2 edges push-to-broadcast; src_ready drops only on a full FIFO (registered count, no pop bypass).

module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign ready = (count_q < CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

module cdb_arbiter #(
  parameter  int NUM_SRC             = 5,
  parameter  int NUM_CDB             = 4,
  parameter  int FIFO_DEPTH          = 2,
  parameter  int DATA_WIDTH          = 32,
  parameter  int PHYS_REG_ADDR_WIDTH = 6,
  localparam int TAG_WIDTH           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic [NUM_SRC-1:0]                            src_valid,
  output logic [NUM_SRC-1:0]                            src_ready,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]            src_data,
  input  logic [NUM_SRC-1:0][PHYS_REG_ADDR_WIDTH-1:0]   src_dest_reg,
  output logic [NUM_CDB-1:0]                            cdb_valid,
  output logic [NUM_CDB-1:0][TAG_WIDTH-1:0]             cdb_tag,
  output logic [NUM_CDB-1:0][DATA_WIDTH-1:0]            cdb_data,
  output logic [NUM_CDB-1:0][PHYS_REG_ADDR_WIDTH-1:0]   cdb_dest_reg
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0]          data;
    logic [PHYS_REG_ADDR_WIDTH-1:0] dest_reg;
  } entry_t;

  entry_t             head [NUM_SRC];
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;

  assign push = src_valid & src_ready & {NUM_SRC{~flush}};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({src_data[i], src_dest_reg[i]}),
      .dout  (head[i]),
      .ready (src_ready[i]),
      .empty (empty[i])
    );
  end

  logic [NUM_CDB-1:0]                          cdb_valid_q, cdb_valid_d;
  logic [NUM_CDB-1:0][TAG_WIDTH-1:0]           cdb_tag_q, cdb_tag_d;
  logic [NUM_CDB-1:0][DATA_WIDTH-1:0]          cdb_data_q, cdb_data_d;
  logic [NUM_CDB-1:0][PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg_q, cdb_dest_reg_d;
  logic [TAG_WIDTH-1:0]                        rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0]   avail;
  logic [TAG_WIDTH:0]   sum;
  logic [TAG_WIDTH-1:0] idx;
  logic                 found;

  // Each channel takes the first still-available source scanning circularly
  // from rr_ptr, so the k-th grant in rotation order lands on channel k.
  always_comb begin
    cdb_valid_d    = '0;
    cdb_tag_d      = '0;
    cdb_data_d     = '0;
    cdb_dest_reg_d = '0;
    pop            = '0;
    rr_ptr_d       = rr_ptr_q;
    avail          = ~empty;
    sum            = '0;
    idx            = '0;
    found          = 1'b0;
    for (int ch = 0; ch < NUM_CDB; ch++) begin
      found = 1'b0;
      for (int off = 0; off < NUM_SRC; off++) begin
        sum = {1'b0, rr_ptr_q} + (TAG_WIDTH+1)'(off);
        if (sum >= (TAG_WIDTH+1)'(NUM_SRC)) begin
          sum = sum - (TAG_WIDTH+1)'(NUM_SRC);
        end
        idx = sum[TAG_WIDTH-1:0];
        if (!found && avail[idx]) begin
          found              = 1'b1;
          avail[idx]         = 1'b0;
          pop[idx]           = 1'b1;
          cdb_valid_d[ch]    = 1'b1;
          cdb_tag_d[ch]      = idx;
          cdb_data_d[ch]     = head[idx].data;
          cdb_dest_reg_d[ch] = head[idx].dest_reg;
          rr_ptr_d           = (idx == TAG_WIDTH'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
    if (flush) begin
      cdb_valid_d    = '0;
      cdb_tag_d      = '0;
      cdb_data_d     = '0;
      cdb_dest_reg_d = '0;
      pop            = '0;
      rr_ptr_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_valid_q    <= '0;
      cdb_tag_q      <= '0;
      cdb_data_q     <= '0;
      cdb_dest_reg_q <= '0;
      rr_ptr_q       <= '0;
    end else begin
      cdb_valid_q    <= cdb_valid_d;
      cdb_tag_q      <= cdb_tag_d;
      cdb_data_q     <= cdb_data_d;
      cdb_dest_reg_q <= cdb_dest_reg_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_tag_q;
  assign cdb_data     = cdb_data_q;
  assign cdb_dest_reg = cdb_dest_reg_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: cycle model predicts every output beat into a queue,
// plus a per-source scoreboard for order, exactly-once delivery and head wait.

module tb_cdb_arbiter;
  localparam int NS = 5;
  localparam int NC = 4;
  localparam int D  = 2;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int TW = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][DW-1:0]  src_data;
  logic [NS-1:0][AW-1:0]  src_dest_reg;
  logic [NC-1:0]          cdb_valid;
  logic [NC-1:0][TW-1:0]  cdb_tag;
  logic [NC-1:0][DW-1:0]  cdb_data;
  logic [NC-1:0][AW-1:0]  cdb_dest_reg;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] r;
  } ent_t;

  typedef struct packed {
    logic [NC-1:0]         v;
    logic [NC-1:0][TW-1:0] t;
    logic [NC-1:0][DW-1:0] d;
    logic [NC-1:0][AW-1:0] r;
  } out_t;

  out_t          exp_q[$];
  ent_t          mq[NS][$];
  ent_t          sent[NS][$];
  logic [DW-1:0] got[$];
  int            mrr = 0;
  int            errors = 0;
  int            checks = 0;
  int            stall[NS];
  int            max_stall = 0;
  bit            saw_not_rdy = 1'b0;
  int            total;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_SRC             (NS),
    .NUM_CDB             (NC),
    .FIFO_DEPTH          (D),
    .DATA_WIDTH          (DW),
    .PHYS_REG_ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_data     (src_data),
    .src_dest_reg (src_dest_reg),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_dest_reg (cdb_dest_reg)
  );

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic rnd_data();
    for (int s = 0; s < NS; s++) begin
      src_data[s]     = $urandom();
      src_dest_reg[s] = AW'($urandom());
    end
  endtask

  // One clock: predict, advance the model, cross the edge, compare.
  task automatic cyc();
    out_t          e;
    out_t          o;
    ent_t          x;
    int            n;
    int            nrr;
    int            t;
    logic [NS-1:0] g, rdy, pushed, elig, bc;
    e = '0; n = 0; nrr = mrr; g = '0; pushed = '0; bc = '0;
    for (int s = 0; s < NS; s++) rdy[s] = (mq[s].size() < D);
    for (int off = 0; off < NS; off++) begin
      int s;
      s = (mrr + off) % NS;
      if (mq[s].size() > 0 && n < NC) begin
        e.v[n] = 1'b1;
        e.t[n] = TW'(s);
        e.d[n] = mq[s][0].d;
        e.r[n] = mq[s][0].r;
        g[s]   = 1'b1;
        nrr    = (s + 1) % NS;
        n++;
      end
    end
    if (!reset) begin
      chk("src_ready", src_ready, rdy);
      if (src_ready != '1) saw_not_rdy = 1'b1;
    end
    if (reset || flush) begin
      e = '0;
      for (int s = 0; s < NS; s++) begin
        mq[s].delete();
        sent[s].delete();
      end
      mrr = 0;
    end else begin
      mrr = nrr;
      for (int s = 0; s < NS; s++) if (g[s]) void'(mq[s].pop_front());
      for (int s = 0; s < NS; s++) begin
        if (src_valid[s] && rdy[s]) begin
          x.d = src_data[s];
          x.r = src_dest_reg[s];
          mq[s].push_back(x);
          sent[s].push_back(x);
          pushed[s] = 1'b1;
        end
      end
    end
    exp_q.push_back(e);
    for (int s = 0; s < NS; s++) elig[s] = (sent[s].size() - int'(pushed[s])) > 0;

    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    chk("cdb_valid", cdb_valid, o.v);
    chk("cdb_tag", cdb_tag, o.t);
    chk("cdb_data", cdb_data, o.d);
    chk("cdb_dest_reg", cdb_dest_reg, o.r);
    for (int ch = 0; ch < NC; ch++) begin
      if (cdb_valid[ch] === 1'b1) begin
        t = int'(cdb_tag[ch]);
        if (t < NS) begin
          chk("sb_pending", sent[t].size() > 0, 1);
          if (sent[t].size() > 0) begin
            chk("sb_order", {cdb_data[ch], cdb_dest_reg[ch]}, sent[t].pop_front());
            bc[t] = 1'b1;
          end
        end
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (elig[s] && !bc[s]) stall[s]++;
      else stall[s] = 0;
      if (stall[s] > max_stall) max_stall = stall[s];
    end
  endtask

  task automatic rec();
    if (cdb_valid[0] === 1'b1 && cdb_tag[0] === TW'(1)) got.push_back(cdb_data[0]);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; src_valid = '1;
    rnd_data();
    cyc(); cyc();
    chk("rst_valid", cdb_valid, 4'b0000);
    reset = 1'b0; src_valid = '0;
    chk("rst_ready", src_ready, 5'b11111);
    repeat (3) cyc();

    // Single push from src2
    src_valid = 5'b00100; src_data[2] = 32'hDEADBEEF; src_dest_reg[2] = 6'h15;
    cyc();
    src_valid = '0;
    cyc();
    chk("sp_valid", cdb_valid, 4'b0001);
    chk("sp_tag", cdb_tag[0], 2);
    chk("sp_data", cdb_data[0], 32'hDEADBEEF);
    chk("sp_dest", cdb_dest_reg[0], 6'h15);
    cyc();
    chk("sp_idle", cdb_valid, 4'b0000);

    // Flush on an idle bus returns rr_ptr to 0
    flush = 1'b1; cyc(); flush = 1'b0;

    // Oversubscription
    src_valid = '1; rnd_data(); cyc();
    src_valid = '0; cyc();
    chk("os_valid", cdb_valid, 4'b1111);
    for (int ch = 0; ch < NC; ch++) chk("os_tag", cdb_tag[ch], ch);
    cyc();
    chk("os_valid2", cdb_valid, 4'b0001);
    chk("os_tag4", cdb_tag[0], 4);
    src_valid = 5'b00011; rnd_data(); cyc();
    src_valid = '0; cyc();
    chk("os_rr", {cdb_valid, cdb_tag[1], cdb_tag[0]}, {4'b0011, 3'd1, 3'd0});
    cyc();

    // Saturation
    for (int s = 0; s < NS; s++) stall[s] = 0;
    max_stall = 0; saw_not_rdy = 1'b0;
    src_valid = '1;
    repeat (50) begin rnd_data(); cyc(); end
    src_valid = '0;
    repeat (4) cyc();
    total = 0;
    for (int s = 0; s < NS; s++) total += sent[s].size();
    chk("sat_stall", max_stall <= 1, 1);
    chk("sat_rdy_low", saw_not_rdy, 1);
    chk("sat_drain", total, 0);

    // Flush mid-stream with FIFOs loaded
    src_valid = '1;
    repeat (3) begin rnd_data(); cyc(); end
    flush = 1'b1; rnd_data(); cyc(); flush = 1'b0;
    chk("fl_valid", cdb_valid, 4'b0000);
    src_valid = 5'b00001; src_data[0] = 32'hCAFEF00D; src_dest_reg[0] = 6'h2A;
    cyc();
    src_valid = '0;
    cyc();
    chk("fl_new", {cdb_valid, cdb_tag[0], cdb_data[0], cdb_dest_reg[0]},
        {4'b0001, 3'd0, 32'hCAFEF00D, 6'h2A});
    repeat (2) cyc();

    // Pointer wrap on src1
    for (int i = 1; i <= 7; i++) begin
      src_valid = 5'b00010; src_data[1] = DW'(i); src_dest_reg[1] = AW'(i);
      cyc(); rec();
    end
    src_valid = '0;
    repeat (3) begin cyc(); rec(); end
    chk("wr_count", got.size(), 7);
    for (int i = 0; i < 7; i++) chk("wr_val", got[i], i + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
